arp_tx_multi: RTL

ARP_TX_MULTI -- requirements
Module: arp_tx_multi

---
 rtl/arp_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/arp_tx_multi.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, frame descriptor and beat formatter for the ARP transmit path.
// One frame is six 64-bit beats; the Ethernet header travels on the user sideband.
package arp_pkg;

    localparam logic [15:0] ARP_HW_TYPE     = 16'd1;
    localparam logic [15:0] ARP_PROTO_IPV4  = 16'h0800;
    localparam logic [7:0]  ARP_HW_LEN      = 8'd6;
    localparam logic [7:0]  ARP_PROTO_LEN   = 8'd4;
    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_PAYLOAD_LEN = 16'd48;
    localparam int          ARP_FRAME_BEATS = 6;
    localparam logic [2:0]  ARP_LAST_BEAT   = 3'(ARP_FRAME_BEATS - 1);
    localparam logic [47:0] BCAST_MAC       = 48'hFF_FF_FF_FF_FF_FF;

    typedef enum logic [15:0] {
        ARP_OP_REQUEST = 16'd1,
        ARP_OP_REPLY   = 16'd2
    } arp_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } arp_state_e;

    typedef struct packed {
        arp_op_e     opcode;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [47:0] tgt_mac;
        logic [31:0] tgt_ip;
    } arp_frame_t;

    function automatic logic [63:0] arp_beat(input arp_frame_t f, input logic [2:0] beat);
        case (beat)
            3'd0:    return {ARP_HW_TYPE, ARP_PROTO_IPV4, ARP_HW_LEN, ARP_PROTO_LEN, f.opcode};
            3'd1:    return {f.src_mac, f.src_ip[31:16]};
            3'd2:    return {f.src_ip[15:0], f.tgt_mac};
            3'd3:    return {f.tgt_ip, 32'd0};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [79:0] arp_user(input logic [47:0] dst_mac);
        return {ARP_PAYLOAD_LEN, dst_mac, ETH_TYPE_ARP};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and registered full/empty flags.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int P_WIDTH = 80,
    parameter int P_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [P_WIDTH-1:0] i_wr_data,
    input  logic               i_rd_en,
    output logic [P_WIDTH-1:0] o_rd_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q, count_d;
    logic               full_q, empty_q;
    logic               do_wr, do_rd;

    assign do_wr = i_wr_en && !full_q;
    assign do_rd = i_rd_en && !empty_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags define validity, which keeps it mappable to RAM.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW + 1)'(P_DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_full    = full_q;
    assign o_empty   = empty_q;

endmodule

// File: rtl/arp_tx_multi.sv
// ARP frame transmitter: queued replies take strict priority over round-robin
// multi-channel requests; frames stream out as six 64-bit AXI-Stream beats.
module arp_tx_multi #(
    parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
    parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06,
    parameter int          P_REQ_CH       = 2,
    parameter int          P_REPLY_DEPTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_src_ip,
    input  logic                  i_src_ip_valid,
    input  logic [47:0]           i_src_mac,
    input  logic                  i_src_mac_valid,
    input  logic                  i_reply_valid,
    input  logic [47:0]           i_reply_mac,
    input  logic [31:0]           i_reply_ip,
    input  logic [P_REQ_CH-1:0]   i_req_valid,
    input  logic [32*P_REQ_CH-1:0] i_req_ip,
    output logic [P_REQ_CH-1:0]   o_req_pending,
    output logic [15:0]           o_reply_drop_cnt,
    output logic [63:0]           m_axis_arp_data,
    output logic [79:0]           m_axis_arp_user,
    output logic [7:0]            m_axis_arp_keep,
    output logic                  m_axis_arp_last,
    output logic                  m_axis_arp_valid,
    input  logic                  m_axis_arp_ready
);

    import arp_pkg::*;

    localparam int CH_W = (P_REQ_CH > 1) ? $clog2(P_REQ_CH) : 1;

    logic [31:0]         src_ip_q;
    logic [47:0]         src_mac_q;
    logic [P_REQ_CH-1:0] pending_q, pending_d;
    logic [31:0]         req_ip_q [P_REQ_CH];
    logic [31:0]         req_ip_d [P_REQ_CH];
    logic [CH_W-1:0]     rr_ptr_q, rr_idx;
    logic                rr_found;
    logic [15:0]         drop_cnt_q;

    arp_state_e  state_q;
    logic [2:0]  beat_q;
    arp_frame_t  frame_q, frame_sel;
    logic [47:0] dst_sel;
    logic [63:0] data_q;
    logic [79:0] user_q;
    logic        last_q, valid_q;

    logic        fifo_full, fifo_empty;
    logic [79:0] fifo_rd_data;
    logic        beat_accept, frame_done, can_select, sel_reply, sel_req, select;

    sync_fifo #(
        .P_WIDTH (80),
        .P_DEPTH (P_REPLY_DEPTH)
    ) u_reply_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_reply_valid && !fifo_full),
        .i_wr_data ({i_reply_mac, i_reply_ip}),
        .i_rd_en   (sel_reply),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    assign beat_accept = valid_q && m_axis_arp_ready;
    assign frame_done  = (state_q == ST_SEND) && beat_accept && (beat_q == ARP_LAST_BEAT);
    assign can_select  = (state_q == ST_IDLE) || frame_done;
    assign sel_reply   = can_select && !fifo_empty;
    assign sel_req     = can_select && fifo_empty && rr_found;
    assign select      = sel_reply || sel_req;

    // Search starts at the channel after the one served last.
    always_comb begin
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        for (int i = 0; i < P_REQ_CH; i++) begin
            if (!rr_found && pending_q[(int'(rr_ptr_q) + i) % P_REQ_CH]) begin
                rr_found = 1'b1;
                rr_idx   = CH_W'((int'(rr_ptr_q) + i) % P_REQ_CH);
            end
        end
    end

    always_comb begin
        frame_sel         = '0;
        frame_sel.src_mac = src_mac_q;
        frame_sel.src_ip  = src_ip_q;
        if (sel_reply) begin
            frame_sel.opcode  = ARP_OP_REPLY;
            frame_sel.tgt_mac = fifo_rd_data[79:32];
            frame_sel.tgt_ip  = fifo_rd_data[31:0];
            dst_sel           = fifo_rd_data[79:32];
        end else begin
            frame_sel.opcode  = ARP_OP_REQUEST;
            frame_sel.tgt_ip  = req_ip_q[rr_idx];
            dst_sel           = BCAST_MAC;
        end
    end

    // A pulse in the same cycle its channel is selected re-arms the channel.
    always_comb begin
        pending_d = pending_q;
        req_ip_d  = req_ip_q;
        if (sel_req) pending_d[rr_idx] = 1'b0;
        for (int k = 0; k < P_REQ_CH; k++) begin
            if (i_req_valid[k]) begin
                pending_d[k] = 1'b1;
                req_ip_d[k]  = i_req_ip[32*k +: 32];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_ip_q   <= P_SRC_IP_ADDR;
            src_mac_q  <= P_SRC_MAC_ADDR;
            pending_q  <= '0;
            req_ip_q   <= '{default: '0};
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (i_src_ip_valid)  src_ip_q  <= i_src_ip;
            if (i_src_mac_valid) src_mac_q <= i_src_mac;
            pending_q <= pending_d;
            req_ip_q  <= req_ip_d;
            if (sel_req) begin
                rr_ptr_q <= (rr_idx == CH_W'(P_REQ_CH - 1)) ? '0 : rr_idx + 1'b1;
            end
            if (i_reply_valid && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            frame_q <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (select) begin
            state_q <= ST_SEND;
            beat_q  <= '0;
            frame_q <= frame_sel;
            data_q  <= arp_beat(frame_sel, 3'd0);
            user_q  <= arp_user(dst_sel);
            last_q  <= 1'b0;
            valid_q <= 1'b1;
        end else if ((state_q == ST_SEND) && beat_accept) begin
            if (beat_q == ARP_LAST_BEAT) begin
                state_q <= ST_IDLE;
                beat_q  <= '0;
                data_q  <= '0;
                user_q  <= '0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                beat_q <= beat_q + 3'd1;
                data_q <= arp_beat(frame_q, beat_q + 3'd1);
                last_q <= ((beat_q + 3'd1) == ARP_LAST_BEAT);
            end
        end
    end

    assign o_req_pending    = pending_q;
    assign o_reply_drop_cnt = drop_cnt_q;
    assign m_axis_arp_data  = data_q;
    assign m_axis_arp_user  = user_q;
    assign m_axis_arp_keep  = 8'hFF;
    assign m_axis_arp_last  = last_q;
    assign m_axis_arp_valid = valid_q;

endmodule
